multiport_reg_file: RTL and testbench
=====================================

// Module: multiport_reg_file
// PURPOSE
//  Parametrised register file for the WISC datapath, generalising the per-bit storage cell to a
//  full array. NUM_REGS x DATA_W storage, NUM_RD combinational read ports, one write port.
//  Half-word write modes support the load-lower/load-higher-byte instructions.
//  Same-cycle write-to-read bypass now also covers half-word writes, using the merged value.
//  Sits between decode (read addresses) and writeback (write port).
// PARAMETERS
//  DATA_W    16  register width in bits; must be even, HALF = DATA_W/2
//  NUM_REGS  16  number of registers, >=2; AW = $clog2(NUM_REGS) (localparam)
//  NUM_RD     2  number of independent read ports, >=1
// PORTS
//  clk      in   1              system clock, rising edge
//  rst      in   1              asynchronous, active-low reset (0 = reset)
//  wr_en    in   1              write request this cycle
//  wr_addr  in   AW             destination register
//  wr_mode  in   2              00 full, 01 low half, 10 high half, 11 reserved (no write)
//  wr_data  in   DATA_W         write data; half modes use wr_data[HALF-1:0] only
//  rd_addr  in   NUM_RD*AW      port i address = rd_addr[i*AW +: AW]
//  rd_data  out  NUM_RD*DATA_W  port i data = rd_data[i*DATA_W +: DATA_W], combinational
// BEHAVIOUR
//  - Reset (rst=0, async): all registers clear to 0 immediately; rd_data reads 0 on every port.
//  - Register 0 is hardwired zero: writes to it are dropped; reads always return 0, no bypass.
//  - Write commits on rising clk when wr_en=1, rst=1, wr_addr!=0, wr_mode!=11. Merged value M:
//      00: M = wr_data
//      01: M = {reg[wr_addr][DATA_W-1:HALF], wr_data[HALF-1:0]}
//      10: M = {wr_data[HALF-1:0], reg[wr_addr][HALF-1:0]}
//  - wr_addr >= NUM_REGS (non-power-of-2 depth): write dropped. Read of such an address returns 0.
//  - Read latency 0. For each port i:
//      rd_data_i = M if the write above is valid and wr_addr==rd_addr_i; else reg[rd_addr_i].
//    All ports may read the same address, including the write target, in the same cycle.
//  - wr_mode 11 with wr_en=1: no state change, no bypass; not an error.
//  - Reset asserted in the same cycle as a write: reset wins; the write is lost.
// CONFIGURATION
//  REGFILE_SCOREBOARD_EN defined: adds a per-register busy bit for in-flight loads.
//   extra ports:  rsv_en in 1, rsv_addr in AW, rd_busy out NUM_RD (bit i for port i)
//   - rsv_en at a clk edge sets busy[rsv_addr]; a valid write clears busy[wr_addr].
//   - Same edge, same address, rsv and write: set wins (a new producer was issued).
//   - busy[0] is always 0; rsv_addr >= NUM_REGS is ignored; reset clears all busy bits.
//   - rd_busy[i] = busy[rd_addr_i] & ~(valid write to rd_addr_i this cycle); the bypass covers it.
//  REGFILE_SCOREBOARD_EN undefined: no busy state, extra ports are absent, all else identical.
// TESTING
//  1 reset: preload r1..r15 = 0xFFFF, pulse rst=0 mid-cycle -> every rd_data = 0 before next edge.
//  2 write/read: full write r5=0x1234, next cycle rd_addr0=5, rd_addr1=5 -> both ports 0x1234.
//  3 half modes: r3=0xABCD; mode 01, data 0x0012 -> 0xAB12; then mode 10, data 0x0034 -> 0x3412.
//  4 bypass: r7=0x1111; same cycle mode 10, data 0x00EE, rd_addr0=7 -> rd_data0=0xEE11 pre-edge.
//    Same cycle, rd_addr1=6 -> port 1 reads r6 unaffected.
//  5 r0 / reserved: write 0xBEEF to r0 -> reads 0; mode 11 write to r4=0x0042 -> r4 stays 0x0042.
//  6 scoreboard (macro on): rsv r9 -> rd_busy=1 next cycle; write r9 -> rd_busy=0 in the write
//    cycle (bypass); same-edge rsv+write on r9 -> busy stays 1.

Source files
------------

// File: rtl/multiport_reg_file_if.sv
// Write/read bus of the WISC register file; decode drives reads, writeback drives writes.
// REGFILE_SCOREBOARD_EN adds the reservation port and per-read busy flags.
interface multiport_reg_file_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [1:0]               wr_mode;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
`ifdef REGFILE_SCOREBOARD_EN
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic [NUM_RD-1:0]        rd_busy;

    modport master (
        output wr_en, wr_addr, wr_mode, wr_data,
        output rd_addr, rsv_en, rsv_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, wr_data,
        input  rd_addr, rsv_en, rsv_addr,
        output rd_data, rd_busy
    );
`else
    modport master (
        output wr_en, wr_addr, wr_mode, wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_mode, wr_data,
        input  rd_addr,
        output rd_data
    );
`endif
endinterface

// File: rtl/multiport_reg_file.sv
// NUM_REGS x DATA_W register file, NUM_RD combinational reads with write bypass.
// Optional REGFILE_SCOREBOARD_EN: per-register busy bits for in-flight loads.
module multiport_reg_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2
) (
    input logic                 clk,
    input logic                 rst,
    multiport_reg_file_if.slave bus
);
    localparam int AW   = $clog2(NUM_REGS);
    localparam int HALF = DATA_W / 2;
    localparam bit POW2 = ((1 << AW) == NUM_REGS);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [AW-1:0]     addr_t;

    word_t regs_q [NUM_REGS];
    word_t regs_d [NUM_REGS];
    word_t wr_old;
    word_t wr_merged;
    logic  wr_ok;

    function automatic logic in_rng(input addr_t a);
        if (POW2) return 1'b1;
        return ({1'b0, a} < (AW+1)'(NUM_REGS));
    endfunction

    // A write is live only out of reset; r0 and mode 11 never write or bypass.
    assign wr_ok = rst && bus.wr_en
                && (bus.wr_mode != 2'b11)
                && (bus.wr_addr != '0)
                && in_rng(bus.wr_addr);

    always_comb begin
        wr_old    = '0;
        if (in_rng(bus.wr_addr)) wr_old = regs_q[bus.wr_addr];
        wr_merged = wr_old;
        case (bus.wr_mode)
            2'b00:   wr_merged = bus.wr_data;
            2'b01:   wr_merged = {wr_old[DATA_W-1:HALF],
                                  bus.wr_data[HALF-1:0]};
            2'b10:   wr_merged = {bus.wr_data[HALF-1:0],
                                  wr_old[HALF-1:0]};
            default: wr_merged = wr_old;
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_ok) regs_d[bus.wr_addr] = wr_merged;
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) regs_q <= '{default: '0};
        else      regs_q <= regs_d;
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Reservation is applied after the clear so a re-issued producer wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
        if (bus.rsv_en && (bus.rsv_addr != '0)
            && in_rng(bus.rsv_addr))
            busy_d[bus.rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end
`endif

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        addr_t ra;
        word_t rv;
        logic  hit;

        assign ra  = bus.rd_addr[p*AW +: AW];
        assign hit = wr_ok && (bus.wr_addr == ra);

        always_comb begin
            rv = '0;
            if (ra != '0 && in_rng(ra)) begin
                if (hit) rv = wr_merged;
                else     rv = regs_q[ra];
            end
        end

        assign bus.rd_data[p*DATA_W +: DATA_W] = rv;

`ifdef REGFILE_SCOREBOARD_EN
        logic bz;

        always_comb begin
            bz = 1'b0;
            if (in_rng(ra)) bz = busy_q[ra] && !hit;
        end

        assign bus.rd_busy[p] = bz;
`endif
    end
endmodule

// File: tb/tb_multiport_reg_file.sv
// Randomized scoreboard bench for multiport_reg_file against an array model.
// Busy flags are checked only when REGFILE_SCOREBOARD_EN is defined.
module tb_multiport_reg_file;
    localparam int DW  = 16;
    localparam int NR  = 16;
    localparam int NRD = 2;

    typedef struct {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  bz;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multiport_reg_file_if #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)
    ) bus ();

    multiport_reg_file #(
        .DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    int mem  [NR];
    bit busy [NR];

    function automatic int rd_model(int ra, bit valid, int wa, int m);
        if (ra == 0) return 0;
        if (valid && wa == ra) return m;
        return mem[ra];
    endfunction

    task automatic step(input bit en, input int wa, input int mode,
                        input int wd, input int ra0, input int ra1,
                        input bit rv, input int rva, input string nm);
        exp_t e;
        bit   valid;
        int   old, m;
        bus.wr_en   = en;
        bus.wr_addr = 4'(wa);
        bus.wr_mode = 2'(mode);
        bus.wr_data = 16'(wd);
        bus.rd_addr = {4'(ra1), 4'(ra0)};
`ifdef REGFILE_SCOREBOARD_EN
        bus.rsv_en   = rv;
        bus.rsv_addr = 4'(rva);
`endif
        if (!rst) begin
            foreach (mem[i]) begin
                mem[i]  = 0;
                busy[i] = 0;
            end
        end
        old   = mem[wa];
        valid = rst && en && wa != 0 && mode != 3;
        case (mode)
            0:       m = wd & 'hFFFF;
            1:       m = (old & 'hFF00) | (wd & 'h00FF);
            2:       m = ((wd & 'hFF) << 8) | (old & 'hFF);
            default: m = old;
        endcase
        e.d0 = 16'(rd_model(ra0, valid, wa, m));
        e.d1 = 16'(rd_model(ra1, valid, wa, m));
        e.bz[0] = busy[ra0] && !(valid && wa == ra0);
        e.bz[1] = busy[ra1] && !(valid && wa == ra1);
        e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        if (rst) begin
            if (valid) begin
                mem[wa]  = m;
                busy[wa] = 0;
            end
            if (rv && rva != 0) busy[rva] = 1;
        end
        #1;
    endtask

    task automatic wr(input int wa, input int mode, input int wd,
                      input string nm);
        step(1, wa, mode, wd, 0, 0, 0, 0, nm);
    endtask

    task automatic rd(input int ra0, input int ra1, input string nm);
        step(0, 0, 0, 0, ra0, ra1, 0, 0, nm);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (bus.rd_data[15:0] !== e.d0) begin
                n_fail++;
                $display("FAIL %s port0: got %h want %h",
                         e.nm, bus.rd_data[15:0], e.d0);
            end
            n_tests++;
            if (bus.rd_data[31:16] !== e.d1) begin
                n_fail++;
                $display("FAIL %s port1: got %h want %h",
                         e.nm, bus.rd_data[31:16], e.d1);
            end
`ifdef REGFILE_SCOREBOARD_EN
            n_tests++;
            if (bus.rd_busy !== e.bz) begin
                n_fail++;
                $display("FAIL %s busy: got %b want %b",
                         e.nm, bus.rd_busy, e.bz);
            end
`endif
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en   = 0;
        bus.wr_addr = '0;
        bus.wr_mode = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
`ifdef REGFILE_SCOREBOARD_EN
        bus.rsv_en   = 0;
        bus.rsv_addr = '0;
`endif
        foreach (mem[i]) begin
            mem[i]  = 0;
            busy[i] = 0;
        end
        @(posedge clk);
        #1;
        rd(5, 15, "reset_state");
        rst = 1'b1;

        for (int r = 1; r < 16; r++)
            step(1, r, 0, 'hFFFF, r, r - 1, 0, 0, "preload");
        rst = 1'b0;
        step(1, 2, 0, 'h5555, 1, 15, 0, 0, "async_reset");
        rst = 1'b1;
        rd(2, 14, "reset_wins");

        wr(5, 0, 'h1234, "wr_r5");
        rd(5, 5, "full_rw");

        wr(3, 0, 'hABCD, "wr_r3");
        step(1, 3, 1, 'h0012, 3, 0, 0, 0, "half_lo_byp");
        rd(3, 3, "half_lo");
        wr(3, 2, 'h0034, "half_hi_wr");
        rd(3, 3, "half_hi");

        wr(7, 0, 'h1111, "wr_r7");
        wr(6, 0, 'h6666, "wr_r6");
        step(1, 7, 2, 'h00EE, 7, 6, 0, 0, "bypass");
        rd(7, 6, "bypass_after");

        step(1, 0, 0, 'hBEEF, 0, 0, 0, 0, "r0_write");
        rd(0, 0, "r0_read");
        wr(4, 0, 'h0042, "wr_r4");
        step(1, 4, 3, 'h9999, 4, 4, 0, 0, "mode11");
        rd(4, 4, "mode11_after");

        step(0, 0, 0, 0, 9, 8, 1, 9, "rsv_r9");
        rd(9, 9, "busy_set");
        step(1, 9, 0, 'h0999, 9, 8, 0, 0, "busy_byp");
        rd(9, 9, "busy_clr");
        step(1, 9, 0, 'h0AAA, 9, 9, 1, 9, "rsv_wr_same");
        rd(9, 9, "set_wins");

        for (int k = 0; k < 400; k++) begin
            int wa, ra0, ra1;
            wa  = $urandom_range(0, 15);
            ra0 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, 15);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 15);
            if ($urandom_range(0, 63) == 0) rst = 1'b0;
            step($urandom_range(0, 3) != 0, wa, $urandom_range(0, 3),
                 $urandom_range(0, 'hFFFF), ra0, ra1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 15), "random");
            rst = 1'b1;
        end

        repeat (3) @(negedge clk);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
